crono_countdown: RTL

//  Countdown engine for the chronometer. Consumes the BCD HH:MM:SS value produced by the time-edit block.
//  On load it latches that value. On start it counts the value down once per second, from an internal prescaler.
//  At 00:00:00 it flags expiry. Its outputs drive the display mux and the alarm buzzer logic.

---
 rtl/crono_pkg.sv | 30 +++
 rtl/bcd_digit_dec.sv | 24 ++
 rtl/crono_countdown.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/crono_pkg.sv
// Shared types and constants for the chronometer countdown engine.
// Holds the FSM state codes, the BCD time bundle and the load validity check.
package crono_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t PAUSED = 2'd1;
    localparam state_t RUN    = 2'd2;
    localparam state_t RING   = 2'd3;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
    } bcd_time_t;

    localparam logic [3:0] DIG_MAX   = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [3:0] HTENS_MAX = 4'd2;
    localparam logic [7:0] HOURS_MAX = 8'h23;

    // Hour tens needs no own check: any value above 2 already exceeds 8'h23.
    function automatic logic time_valid(input bcd_time_t v);
        return (v.h <= HOURS_MAX) && (v.h[3:0] <= DIG_MAX)
            && (v.m[7:4] <= TENS_MAX) && (v.m[3:0] <= DIG_MAX)
            && (v.s[7:4] <= TENS_MAX) && (v.s[3:0] <= DIG_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown borrow chain.
// Wraps 0 to its limit and asserts borrow_out when a borrow passes through.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic [3:0] limit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                next_digit = limit;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/crono_countdown.sv
// Countdown engine: BCD HH:MM:SS load, per-second decrement, expiry pulse.
// Define CRONO_RING_EN to add the RING state that holds the alarm request.
module crono_countdown
    import crono_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int RING_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] h_in,
    input  logic [7:0] m_in,
    input  logic [7:0] s_in,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] h_out,
    output logic [7:0] m_out,
    output logic [7:0] s_out,
    output logic       running,
    output logic       done,
    output logic       load_err,
    output logic       ring
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
    localparam logic [23:0] LIMS = {HTENS_MAX, DIG_MAX, TENS_MAX,
                                    DIG_MAX, TENS_MAX, DIG_MAX};

    if (CLK_HZ < 2 || RING_SECS < 1) begin : g_bad_cfg
        $error("crono_countdown: CLK_HZ must be >= 2, RING_SECS >= 1");
    end

    state_t        state;
    logic [PW-1:0] presc;
    logic [23:0]   t;
    logic [23:0]   t_dec;
    logic [6:0]    b;
    bcd_time_t     in_t;
    logic          in_ok;
    logic          wrap;
    logic          tick;

    assign in_t  = {h_in, m_in, s_in};
    assign in_ok = time_valid(in_t);
    assign wrap  = (presc == PMAX);
    assign tick  = (state == RUN) && wrap;

    // Seconds units always borrow; b[6] set means the time was already zero.
    assign b[0] = 1'b1;
    for (genvar i = 0; i < 6; i++) begin : g_dig
        bcd_digit_dec u_dig (
            .digit     (t[4*i +: 4]),
            .limit     (LIMS[4*i +: 4]),
            .borrow_in (b[i]),
            .next_digit(t_dec[4*i +: 4]),
            .borrow_out(b[i+1])
        );
    end

`ifdef CRONO_RING_EN
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [RW-1:0] RLAST = RW'(RING_SECS - 1);
    localparam state_t EXPIRE_NEXT = RING;

    logic [RW-1:0] ring_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != RING) ring_cnt <= '0;
        else if (wrap)              ring_cnt <= ring_cnt + 1'b1;
    end

    assign ring = (state == RING);
`else
    localparam state_t EXPIRE_NEXT = IDLE;

    assign ring = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            t        <= '0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (in_ok) begin
                    t     <= in_t;
                    presc <= '0;
                    state <= (in_t != '0) ? PAUSED : IDLE;
                end else begin
                    load_err <= 1'b1;
                    if (state == RING) state <= IDLE;
                end
            end else begin
                case (state)
                    RUN: begin
                        // A stop on a tick cycle drops the tick and freezes the prescaler.
                        if (stop) begin
                            state <= PAUSED;
                        end else begin
                            presc <= wrap ? '0 : presc + 1'b1;
                            if (tick && !b[6]) begin
                                t <= t_dec;
                                if (t == 24'h00_00_01) begin
                                    done  <= 1'b1;
                                    state <= EXPIRE_NEXT;
                                end
                            end
                        end
                    end
                    PAUSED: begin
                        if (start && !stop) state <= RUN;
                    end
`ifdef CRONO_RING_EN
                    RING: begin
                        if (start || stop) begin
                            state <= IDLE;
                        end else begin
                            presc <= wrap ? '0 : presc + 1'b1;
                            if (wrap && ring_cnt == RLAST) state <= IDLE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign h_out   = t[23:16];
    assign m_out   = t[15:8];
    assign s_out   = t[7:0];
    assign running = (state == RUN);

endmodule
